// File: rtl/clk_div_gen_pkg.sv
// Shared definitions for the multi-channel programmable clock divider.
// Holds the per-channel FSM state encoding and the default half-period width.
package clk_div_gen_pkg;

  typedef enum logic [1:0] {
    CLKDIV_IDLE     = 2'd0,
    CLKDIV_RUN      = 2'd1,
    CLKDIV_STOPPING = 2'd2
  } clkdiv_state_e;

  localparam int CLKDIV_DEFAULT_W  = 16;
  localparam int CLKDIV_DEFAULT_CH = 2;

endpackage

// File: rtl/clk_div_gen_channel.sv
// One divider channel: run/stop FSM, half-period counter and pending reload register.
// The divided clock only stops at a falling boundary, so no high phase is ever cut short.
module clk_div_channel
  import clk_div_gen_pkg::*;
#(
  parameter int DIV_W = CLKDIV_DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_enable_i,
  input  logic [DIV_W-1:0] div_value_i,
  input  logic             div_load_i,
  output logic             div_clk_o,
  output logic             tick_o,
  output logic             running_o,
  output logic             load_pend_o
);

  clkdiv_state_e    state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_clk_q, div_clk_d;
  logic             tick_q, tick_d;
  logic             boundary;
  logic             fall;

  // half_q is kept normalised (never 0), so H-1 cannot underflow
  assign boundary = (cnt_q == half_q - DIV_W'(1));
  assign fall     = (state_q != CLKDIV_IDLE) && boundary && div_clk_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    div_clk_d  = div_clk_q;
    tick_d     = 1'b0;

    case (state_q)
      CLKDIV_IDLE: begin
        cnt_d     = '0;
        div_clk_d = 1'b0;
        if (ch_enable_i) state_d = CLKDIV_RUN;
      end
      CLKDIV_RUN, CLKDIV_STOPPING: begin
        if (!ch_enable_i && !div_clk_q) begin
          state_d = CLKDIV_IDLE;
          cnt_d   = '0;
        end else begin
          if (boundary) begin
            cnt_d     = '0;
            div_clk_d = ~div_clk_q;
            tick_d    = ~div_clk_q;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // a stop request during the high phase waits for the falling boundary
          if (ch_enable_i)  state_d = CLKDIV_RUN;
          else if (fall)    state_d = CLKDIV_IDLE;
          else              state_d = CLKDIV_STOPPING;
        end
      end
      default: begin
        state_d   = CLKDIV_IDLE;
        cnt_d     = '0;
        div_clk_d = 1'b0;
      end
    endcase

    if (pend_vld_q && ((state_q == CLKDIV_IDLE) || fall)) begin
      half_d     = (pend_q == '0) ? DIV_W'(1) : pend_q;
      pend_vld_d = 1'b0;
    end

    // a fresh capture always wins, so it is never lost to a same-cycle apply
    if (div_load_i) begin
      pend_d     = div_value_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLKDIV_IDLE;
      cnt_q      <= '0;
      half_q     <= DIV_W'(1);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_clk_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_clk_q  <= div_clk_d;
      tick_q     <= tick_d;
    end
  end

  assign div_clk_o   = div_clk_q;
  assign tick_o      = tick_q;
  assign running_o   = (state_q != CLKDIV_IDLE);
  assign load_pend_o = pend_vld_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable 50% duty clock divider.
// Each channel is an independent clk_div_channel; this level only slices the buses.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int NUM_CH = CLKDIV_DEFAULT_CH,
  parameter int DIV_W  = CLKDIV_DEFAULT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*DIV_W-1:0] div_value,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       load_pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ch_enable_i(ch_enable[i]),
      .div_value_i(div_value[i*DIV_W +: DIV_W]),
      .div_load_i (div_load[i]),
      .div_clk_o  (div_clk[i]),
      .tick_o     (tick[i]),
      .running_o  (running[i]),
      .load_pend_o(load_pend[i])
    );
  end

endmodule
